audio_ctrl: RTL and testbench

//  Register front-end and scheduler for the PCM audio path. Decodes 4 CPU audio registers, drives
//  the pcm block's FIFO write/reset strobes and mode/rate/volume inputs, generates the next_sample

---
 rtl/audio_ctrl_if.sv | 34 +++
 rtl/audio_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_audio_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_ctrl_if.sv
// -----------------------------------------------------------------------------
// audio_ctrl_if
//   CPU register bus for the PCM audio controller.
//   Signals:
//     reg_addr    2  register select (0 CTRL, 1 RATE, 2 DATA, 3 IRQ)
//     reg_wrdata  8  CPU write data
//     reg_write   1  one-cycle write strobe
//     reg_read    1  one-cycle read strobe
//     reg_rddata  8  read data, valid the cycle after reg_read, held until next read
//   Modports: master = CPU side, slave = audio_ctrl side.
// -----------------------------------------------------------------------------
interface audio_ctrl_if;
   logic [1:0] reg_addr;
   logic [7:0] reg_wrdata;
   logic       reg_write;
   logic       reg_read;
   logic [7:0] reg_rddata;

   modport master (
      output reg_addr,
      output reg_wrdata,
      output reg_write,
      output reg_read,
      input  reg_rddata
   );

   modport slave (
      input  reg_addr,
      input  reg_wrdata,
      input  reg_write,
      input  reg_read,
      output reg_rddata
   );
endinterface

// File: rtl/audio_ctrl.sv
// -----------------------------------------------------------------------------
// audio_ctrl
//   Register front-end and scheduler for the PCM audio path. Decodes the four
//   CPU registers, forwards DATA writes to the pcm FIFO, generates the
//   next_sample tick, commits rate/mode/volume only on sample boundaries (or
//   on a FIFO restart) and raises the almost-empty / overflow interrupt.
//   Ports:
//     clk                  system clock
//     rst                  synchronous active-high reset
//     bus                  CPU register bus (audio_ctrl_if.slave)
//     i_fifo_full          pcm FIFO full
//     i_fifo_almost_empty  pcm FIFO almost empty
//     o_next_sample        one-cycle tick every CLK_DIV cycles
//     o_sample_rate        committed rate (<= 128)
//     o_mode_stereo        committed stereo mode
//     o_mode_16bit         committed 16-bit mode
//     o_volume             committed volume
//     o_fifo_reset         one-cycle FIFO reset pulse
//     o_fifo_wrdata        FIFO write data
//     o_fifo_write         one-cycle FIFO write strobe
//     o_irq                level interrupt to CPU
// -----------------------------------------------------------------------------
module audio_ctrl #(
   parameter int CLK_DIV = 512
) (
   input  logic         clk,
   input  logic         rst,
   audio_ctrl_if.slave  bus,
   input  logic         i_fifo_full,
   input  logic         i_fifo_almost_empty,
   output logic         o_next_sample,
   output logic [7:0]   o_sample_rate,
   output logic         o_mode_stereo,
   output logic         o_mode_16bit,
   output logic [3:0]   o_volume,
   output logic         o_fifo_reset,
   output logic [7:0]   o_fifo_wrdata,
   output logic         o_fifo_write,
   output logic         o_irq
);

   localparam int DIV_W = $clog2(CLK_DIV);

   typedef enum logic [1:0] {
      REG_CTRL = 2'd0,
      REG_RATE = 2'd1,
      REG_DATA = 2'd2,
      REG_IRQ  = 2'd3
   } reg_sel_e;

   typedef struct packed {
      logic [7:0] rate;
      logic       mode_16bit;
      logic       mode_stereo;
      logic [3:0] volume;
   } cfg_t;

   logic [DIV_W-1:0] r_div;
   cfg_t             r_shadow;
   cfg_t             r_commit;
   logic             r_fifo_reset;
   logic             r_fifo_write;
   logic [7:0]       r_fifo_wrdata;
   logic             r_aflow_en;
   logic             r_ovf_sticky;
   logic             r_irq;
   logic [7:0]       r_rddata;

   logic             w_tick;
   logic             w_wr_ctrl;
   logic             w_wr_rate;
   logic             w_wr_data;
   logic             w_wr_irq;
   logic             w_restart;
   logic             w_data_ok;
   logic             w_data_drop;
   logic [7:0]       w_rate_clamped;
   logic [7:0]       w_rd_mux;

   assign w_tick      = (r_div == DIV_W'(CLK_DIV - 1));

   assign w_wr_ctrl   = bus.reg_write && (bus.reg_addr == REG_CTRL);
   assign w_wr_rate   = bus.reg_write && (bus.reg_addr == REG_RATE);
   assign w_wr_data   = bus.reg_write && (bus.reg_addr == REG_DATA);
   assign w_wr_irq    = bus.reg_write && (bus.reg_addr == REG_IRQ);

   // A CTRL write with bit7 set restarts the FIFO; that is a clean boundary,
   // so the new configuration is committed at once instead of waiting a tick.
   assign w_restart   = w_wr_ctrl && bus.reg_wrdata[7];

   // fifo_full is sampled per write so back-to-back writes never stall.
   assign w_data_ok   = w_wr_data && !i_fifo_full;
   assign w_data_drop = w_wr_data &&  i_fifo_full;

   assign w_rate_clamped = (bus.reg_wrdata > 8'd128) ? 8'd128 : bus.reg_wrdata;

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      w_rd_mux = 8'h00;
      unique case (bus.reg_addr)
         REG_CTRL: w_rd_mux = {1'b0, i_fifo_full, r_shadow.mode_16bit,
                               r_shadow.mode_stereo, r_shadow.volume};
         REG_RATE: w_rd_mux = r_shadow.rate;
         REG_DATA: w_rd_mux = 8'h00;
         REG_IRQ:  w_rd_mux = {5'b0, r_ovf_sticky,
                               r_aflow_en & i_fifo_almost_empty, r_aflow_en};
         default:  w_rd_mux = 8'h00;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div         <= '0;
         r_shadow      <= '0;
         r_commit      <= '0;
         r_fifo_reset  <= 1'b0;
         r_fifo_write  <= 1'b0;
         r_fifo_wrdata <= 8'h00;
         r_aflow_en    <= 1'b0;
         r_ovf_sticky  <= 1'b0;
         r_irq         <= 1'b0;
         r_rddata      <= 8'h00;
      end else begin
         r_div <= w_tick ? '0 : r_div + 1'b1;

         if (w_wr_ctrl) begin
            r_shadow.mode_16bit  <= bus.reg_wrdata[5];
            r_shadow.mode_stereo <= bus.reg_wrdata[4];
            r_shadow.volume      <= bus.reg_wrdata[3:0];
         end
         if (w_wr_rate) begin
            r_shadow.rate <= w_rate_clamped;
         end

         // Restart commits the CTRL bits being written; a tick commits the
         // shadow as it stood before this edge.
         if (w_restart) begin
            r_commit.rate        <= r_shadow.rate;
            r_commit.mode_16bit  <= bus.reg_wrdata[5];
            r_commit.mode_stereo <= bus.reg_wrdata[4];
            r_commit.volume      <= bus.reg_wrdata[3:0];
         end else if (w_tick) begin
            r_commit <= r_shadow;
         end

         r_fifo_reset <= w_restart;
         r_fifo_write <= w_data_ok;
         if (w_data_ok) begin
            r_fifo_wrdata <= bus.reg_wrdata;
         end

         if (w_wr_irq) begin
            r_aflow_en <= bus.reg_wrdata[0];
         end
         // Set wins over a same-cycle write-1-to-clear.
         if (w_data_drop) begin
            r_ovf_sticky <= 1'b1;
         end else if (w_wr_irq && bus.reg_wrdata[2]) begin
            r_ovf_sticky <= 1'b0;
         end

         r_irq <= (r_aflow_en & i_fifo_almost_empty) | r_ovf_sticky;

         if (bus.reg_read) begin
            r_rddata <= w_rd_mux;
         end
      end
   end

   assign o_next_sample  = w_tick;
   assign o_sample_rate  = r_commit.rate;
   assign o_mode_stereo  = r_commit.mode_stereo;
   assign o_mode_16bit   = r_commit.mode_16bit;
   assign o_volume       = r_commit.volume;
   assign o_fifo_reset   = r_fifo_reset;
   assign o_fifo_wrdata  = r_fifo_wrdata;
   // A FIFO reset in the same output cycle wins over a write.
   assign o_fifo_write   = r_fifo_write & ~r_fifo_reset;
   assign o_irq          = r_irq;
   assign bus.reg_rddata = r_rddata;

endmodule

// File: tb/tb_audio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_audio_ctrl
//   Self-checking bench for audio_ctrl. A transaction-level model tracks the
//   register file and elapsed cycles; a negedge process compares every output
//   against it each cycle, and directed tests add literal expectations.
// -----------------------------------------------------------------------------
module tb_audio_ctrl;
   localparam int CLK_DIV = 512;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_full;
   logic       i_ae;
   logic       o_next_sample;
   logic [7:0] o_sample_rate;
   logic       o_mode_stereo;
   logic       o_mode_16bit;
   logic [3:0] o_volume;
   logic       o_fifo_reset;
   logic [7:0] o_fifo_wrdata;
   logic       o_fifo_write;
   logic       o_irq;

   audio_ctrl_if bus ();

   audio_ctrl #(.CLK_DIV(CLK_DIV)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .bus                 (bus),
      .i_fifo_full         (i_full),
      .i_fifo_almost_empty (i_ae),
      .o_next_sample       (o_next_sample),
      .o_sample_rate       (o_sample_rate),
      .o_mode_stereo       (o_mode_stereo),
      .o_mode_16bit        (o_mode_16bit),
      .o_volume            (o_volume),
      .o_fifo_reset        (o_fifo_reset),
      .o_fifo_wrdata       (o_fifo_wrdata),
      .o_fifo_write        (o_fifo_write),
      .o_irq               (o_irq)
   );

   always #20 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- model ----------------
   bit          chk_en = 1'b0;
   int unsigned m_cyc  = 0;        // clean cycles since last reset
   logic [7:0]  m_sh_rate = 0, m_rate = 0;
   logic        m_sh_16 = 0, m_sh_st = 0, m_16 = 0, m_st = 0;
   logic [3:0]  m_sh_vol = 0, m_vol = 0;
   logic        m_aflow = 0, m_ovf = 0;
   logic        e_reset = 0, e_write = 0, e_irq = 0;
   logic [7:0]  e_wrdata = 0, e_rddata = 0;

   always @(posedge clk) begin
      bit         tick, wr;
      logic [1:0] a;
      logic [7:0] d;
      if (rst) begin
         chk_en = 1'b1;
         m_cyc = 0;
         m_sh_rate = 0; m_rate = 0; m_sh_16 = 0; m_sh_st = 0; m_16 = 0; m_st = 0;
         m_sh_vol = 0; m_vol = 0; m_aflow = 0; m_ovf = 0;
         e_reset = 0; e_write = 0; e_irq = 0; e_wrdata = 0; e_rddata = 0;
      end else begin
         tick = (m_cyc % CLK_DIV) == CLK_DIV - 1;
         wr   = bus.reg_write;
         a    = bus.reg_addr;
         d    = bus.reg_wrdata;
         e_irq = (m_aflow && i_ae) || m_ovf;
         if (bus.reg_read) begin
            case (a)
               2'd0:    e_rddata = {1'b0, i_full, m_sh_16, m_sh_st, m_sh_vol};
               2'd1:    e_rddata = m_sh_rate;
               2'd2:    e_rddata = 8'h00;
               default: e_rddata = {5'b0, m_ovf, m_aflow && i_ae, m_aflow};
            endcase
         end
         e_reset = wr && a == 2'd0 && d[7];
         e_write = wr && a == 2'd2 && !i_full;
         if (e_write) e_wrdata = d;
         if (e_reset) begin
            m_rate = m_sh_rate; m_16 = d[5]; m_st = d[4]; m_vol = d[3:0];
         end else if (tick) begin
            m_rate = m_sh_rate; m_16 = m_sh_16; m_st = m_sh_st; m_vol = m_sh_vol;
         end
         if (wr && a == 2'd0) begin m_sh_16 = d[5]; m_sh_st = d[4]; m_sh_vol = d[3:0]; end
         if (wr && a == 2'd1) m_sh_rate = (d > 8'd128) ? 8'd128 : d;
         if (wr && a == 2'd3) begin
            m_aflow = d[0];
            if (d[2]) m_ovf = 1'b0;
         end
         if (wr && a == 2'd2 && i_full) m_ovf = 1'b1;
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("next_sample", o_next_sample, ((m_cyc % CLK_DIV) == CLK_DIV - 1));
         check("sample_rate", o_sample_rate, m_rate);
         check("mode_16bit",  o_mode_16bit,  m_16);
         check("mode_stereo", o_mode_stereo, m_st);
         check("volume",      o_volume,      m_vol);
         check("fifo_reset",  o_fifo_reset,  e_reset);
         check("fifo_write",  o_fifo_write,  e_write);
         check("fifo_wrdata", o_fifo_wrdata, e_wrdata);
         check("irq",         o_irq,         e_irq);
         check("rddata",      bus.reg_rddata, e_rddata);
      end
   end

   // ---------------- stimulus helpers (entered and left at negedge) ----------------
   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus.reg_addr = a; bus.reg_wrdata = d; bus.reg_write = 1'b1;
      @(negedge clk);
      bus.reg_write = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      bus.reg_addr = a; bus.reg_read = 1'b1;
      @(negedge clk);
      bus.reg_read = 1'b0;
      d = bus.reg_rddata;
   endtask

   task automatic wait_tick();
      int n = 0;
      while (!o_next_sample && n < 2 * CLK_DIV + 8) begin
         @(negedge clk);
         n++;
      end
      check("tick_within_bound", o_next_sample, 1'b1);
   endtask

   logic [7:0] rdv;
   int         pulses, first_at, second_at;
   logic [7:0] data_vec [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      rst = 1'b1; i_full = 1'b0; i_ae = 1'b0;
      bus.reg_addr = 2'd0; bus.reg_wrdata = 8'h00; bus.reg_write = 1'b0; bus.reg_read = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1: reset state and tick spacing
      check("reset_rate",   o_sample_rate, 8'd0);
      check("reset_volume", o_volume, 4'd0);
      check("reset_irq",    o_irq, 1'b0);
      pulses = 0; first_at = -1; second_at = -1;
      for (int k = 0; k < 2 * CLK_DIV; k++) begin
         if (k > 0) @(negedge clk);
         if (o_next_sample) begin
            if (pulses == 0) first_at = k; else second_at = k;
            pulses++;
         end
      end
      check("tick_count",  pulses, 2);
      check("tick_first",  first_at, 511);
      check("tick_second", second_at, 1023);

      // 2: shadow writes wait for the tick; rate clamps
      wait_tick();
      repeat (101) @(negedge clk);
      wr(2'd1, 8'h80);
      wr(2'd0, 8'h3F);
      check("pre_tick_rate",   o_sample_rate, 8'd0);
      check("pre_tick_volume", o_volume, 4'd0);
      wait_tick();
      @(negedge clk);
      check("commit_rate",   o_sample_rate, 8'd128);
      check("commit_16bit",  o_mode_16bit, 1'b1);
      check("commit_stereo", o_mode_stereo, 1'b1);
      check("commit_volume", o_volume, 4'd15);
      wr(2'd1, 8'hC8);
      rd(2'd1, rdv);
      check("rate_clamp_readback", rdv, 8'h80);
      rd(2'd0, rdv);
      check("ctrl_readback", rdv, 8'h3F);

      // 3: FIFO restart commits immediately
      wr(2'd0, 8'h85);
      check("restart_pulse",  o_fifo_reset, 1'b1);
      check("restart_volume", o_volume, 4'd5);
      check("restart_16bit",  o_mode_16bit, 1'b0);
      check("restart_rate",   o_sample_rate, 8'd128);
      @(negedge clk);
      check("restart_pulse_width", o_fifo_reset, 1'b0);

      // 4: back-to-back DATA writes
      for (int i = 0; i < 4; i++) begin
         wr(2'd2, data_vec[i]);
         check("b2b_write", o_fifo_write, 1'b1);
         check("b2b_data",  o_fifo_wrdata, data_vec[i]);
      end
      @(negedge clk);
      check("b2b_write_end", o_fifo_write, 1'b0);

      // 5: overflow while full
      i_full = 1'b1;
      wr(2'd2, 8'h55);
      check("ovf_dropped", o_fifo_write, 1'b0);
      i_full = 1'b0;
      @(negedge clk);
      check("ovf_irq", o_irq, 1'b1);
      rd(2'd3, rdv);
      check("ovf_irq_readback", rdv, 8'h04);
      wr(2'd3, 8'h04);
      @(negedge clk);
      check("ovf_cleared_irq", o_irq, 1'b0);

      // 6: almost-empty interrupt, then reset during a DATA write
      wr(2'd3, 8'h01);
      i_ae = 1'b1;
      @(negedge clk);
      check("aflow_irq_rise", o_irq, 1'b1);
      rd(2'd3, rdv);
      check("aflow_readback", rdv, 8'h03);
      i_ae = 1'b0;
      @(negedge clk);
      check("aflow_irq_fall", o_irq, 1'b0);
      i_ae = 1'b1;
      bus.reg_addr = 2'd2; bus.reg_wrdata = 8'h66; bus.reg_write = 1'b1; rst = 1'b1;
      @(negedge clk);
      bus.reg_write = 1'b0; rst = 1'b0;
      check("rst_no_write",  o_fifo_write, 1'b0);
      check("rst_rate",      o_sample_rate, 8'd0);
      check("rst_volume",    o_volume, 4'd0);
      check("rst_irq",       o_irq, 1'b0);
      check("rst_rddata",    bus.reg_rddata, 8'h00);
      @(negedge clk);
      check("rst_aflow_off", o_irq, 1'b0);
      i_ae = 1'b0;
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
